// File: rtl/enemy_stage_ctrl.sv
// Enemy stage controller: alive mask, {phase,tick} motion state and stage FSM.
// Optional feature macro: ENEMY_SPEEDUP_EN (double-speed motion when <= 5 enemies remain).
module enemy_stage_ctrl #(
  parameter int NUM_ENEMY = 15,
  parameter int TICK_MAX  = 71,
  parameter int FRAME_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 stage_start,
  input  logic                 pause,
  input  logic                 hit_valid,
  input  logic [3:0]           hit_index,
  output logic [NUM_ENEMY-1:0] enemy_state,
  output logic [8:0]           stage_state,
  output logic                 running,
  output logic                 stage_clear
);

  localparam int              DIV_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [7:0]      TICK_WRAP = 8'(TICK_MAX + 1);
  localparam logic [4:0]      NUM_E     = 5'(NUM_ENEMY);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_CLEAR  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_ENEMY-1:0]   enemy_q, enemy_d;
  logic [1:0]             phase_q, phase_d;
  logic [6:0]             tick_q, tick_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   running_q, running_d;
  logic                   clear_q, clear_d;

  logic                   hit_ok;
  logic [NUM_ENEMY-1:0]   hit_mask;
  logic [NUM_ENEMY-1:0]   enemy_hit;
  logic [7:0]             step_inc;
  logic [7:0]             tick_sum;
  logic                   do_step;

`ifdef ENEMY_SPEEDUP_EN
  localparam int CNT_W = $clog2(NUM_ENEMY + 1);

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ENEMY-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_ENEMY; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  always_comb begin
    step_inc = 8'd1;
    if (state_q == S_RUN && popcount(enemy_q) <= CNT_W'(5)) step_inc = 8'd2;
  end
`else
  assign step_inc = 8'd1;
`endif

  // Hit decode: out-of-range indices never form a mask bit.
  always_comb begin
    hit_ok   = hit_valid && ({1'b0, hit_index} < NUM_E);
    hit_mask = '0;
    for (int i = 0; i < NUM_ENEMY; i++)
      if (hit_ok && hit_index == 4'(i)) hit_mask[i] = 1'b1;
    enemy_hit = enemy_q & ~hit_mask;
  end

  assign tick_sum = {1'b0, tick_q} + step_inc;

  always_comb begin
    state_d = state_q;
    enemy_d = enemy_q;
    phase_d = phase_q;
    tick_d  = tick_q;
    div_d   = div_q;
    do_step = 1'b0;

    if (stage_start) begin
      state_d = S_RUN;
      enemy_d = '1;
      phase_d = 2'd0;
      tick_d  = 7'd0;
      div_d   = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          enemy_d = enemy_hit;
          if (pause) begin
            state_d = S_PAUSED;
          end else if (frame_tick) begin
            if (div_q == DIV_LAST) begin
              div_d   = '0;
              do_step = 1'b1;
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        end
        S_PAUSED: begin
          enemy_d = enemy_hit;
          if (!pause) state_d = S_RUN;
        end
        S_CLEAR: state_d = S_IDLE;
        default: ;
      endcase

      // The last kill overrides any pause transition in the same cycle.
      if ((state_q == S_RUN || state_q == S_PAUSED) &&
          (enemy_q & hit_mask) != '0 && enemy_hit == '0)
        state_d = S_CLEAR;

      if (do_step) begin
        if (tick_sum >= TICK_WRAP) begin
          tick_d  = 7'(tick_sum - TICK_WRAP);
          phase_d = phase_q + 2'd1;
        end else begin
          tick_d = tick_sum[6:0];
        end
      end
    end

    running_d = (state_d == S_RUN) || (state_d == S_PAUSED);
    clear_d   = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      enemy_q   <= '0;
      phase_q   <= 2'd0;
      tick_q    <= 7'd0;
      div_q     <= '0;
      running_q <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      enemy_q   <= enemy_d;
      phase_q   <= phase_d;
      tick_q    <= tick_d;
      div_q     <= div_d;
      running_q <= running_d;
      clear_q   <= clear_d;
    end
  end

  assign enemy_state = enemy_q;
  assign stage_state = {phase_q, tick_q};
  assign running     = running_q;
  assign stage_clear = clear_q;

endmodule

// File: tb/tb_enemy_stage_ctrl.sv
// Directed self-checking bench for enemy_stage_ctrl (FRAME_DIV = 2).
module tb_enemy_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        stage_start = 1'b0;
  logic        pause = 1'b0;
  logic        hit_valid = 1'b0;
  logic [3:0]  hit_index = 4'd0;
  logic [14:0] enemy_state;
  logic [8:0]  stage_state;
  logic        running;
  logic        stage_clear;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_ss;

  enemy_stage_ctrl #(.NUM_ENEMY(15), .TICK_MAX(71), .FRAME_DIV(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .stage_start (stage_start),
    .pause       (pause),
    .hit_valid   (hit_valid),
    .hit_index   (hit_index),
    .enemy_state (enemy_state),
    .stage_state (stage_state),
    .running     (running),
    .stage_clear (stage_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [3:0] idx);
    hit_valid = 1'b1;
    hit_index = idx;
    cyc();
    hit_valid = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic start();
    stage_start = 1'b1;
    cyc();
    stage_start = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_enemy",   32'(enemy_state), 32'h0);
    chk("rst_stage",   32'(stage_state), 32'h0);
    chk("rst_running", 32'(running),     32'h0);
    chk("rst_clear",   32'(stage_clear), 32'h0);
    rst_n = 1'b1;
    cyc();

    hit(4'd0);
    frames(2);
    chk("idle_hit_enemy", 32'(enemy_state), 32'h0);
    chk("idle_running",   32'(running),     32'h0);
    chk("idle_stage",     32'(stage_state), 32'h0);

    start();
    chk("start_enemy",   32'(enemy_state), 32'h7FFF);
    chk("start_stage",   32'(stage_state), 32'h0);
    chk("start_running", 32'(running),     32'h1);

    frames(1);
    chk("div_first", 32'(stage_state), 32'h000);
    frames(1);
    chk("div_second", 32'(stage_state), 32'h001);
    frames(142);
    chk("phase1_wrap", 32'(stage_state), 32'h080);
    frames(432);
    chk("phase_wrap0", 32'(stage_state), 32'h000);

    hit(4'd3);
    hit(4'd3);
    hit(4'd15);
    chk("hits_3_3_15", 32'(enemy_state), 32'h7FF7);

    pause = 1'b1;
    cyc();
    chk("pause_running", 32'(running), 32'h1);
    frames(10);
    chk("pause_hold", 32'(stage_state), 32'h000);
    hit(4'd0);
    chk("pause_hit", 32'(enemy_state), 32'h7FF6);
    pause = 1'b0;
    cyc();

    for (int i = 1; i <= 9; i++) if (i != 3) hit(4'(i));
    chk("ten_killed", 32'(enemy_state), 32'h7C00);

`ifdef ENEMY_SPEEDUP_EN
    frames(70);
    chk("fast_tick70", 32'(stage_state), 32'h046);
    frames(2);
    chk("fast_wrap", 32'(stage_state), 32'h080);
    frames(2);
    chk("fast_tick2", 32'(stage_state), 32'h082);
    exp_ss = 9'h082;
`else
    frames(2);
    chk("slow_tick1", 32'(stage_state), 32'h001);
    frames(2);
    chk("slow_tick2", 32'(stage_state), 32'h002);
    exp_ss = 9'h002;
`endif

    for (int i = 10; i <= 13; i++) hit(4'(i));
    chk("one_left",      32'(enemy_state), 32'h4000);
    chk("one_left_clr",  32'(stage_clear), 32'h0);
    hit(4'd14);
    chk("clear_enemy",   32'(enemy_state), 32'h0);
    chk("clear_pulse",   32'(stage_clear), 32'h1);
    chk("clear_running", 32'(running),     32'h0);
    chk("clear_stage",   32'(stage_state), 32'(exp_ss));
    cyc();
    chk("clear_done",    32'(stage_clear), 32'h0);
    chk("idle_running2", 32'(running),     32'h0);
    frames(4);
    hit(4'd1);
    chk("idle_frozen",   32'(stage_state), 32'(exp_ss));
    chk("idle_enemy0",   32'(enemy_state), 32'h0);

    stage_start = 1'b1;
    hit_valid   = 1'b1;
    hit_index   = 4'd5;
    pause       = 1'b1;
    cyc();
    stage_start = 1'b0;
    hit_valid   = 1'b0;
    pause       = 1'b0;
    chk("prio_enemy",   32'(enemy_state), 32'h7FFF);
    chk("prio_stage",   32'(stage_state), 32'h0);
    chk("prio_running", 32'(running),     32'h1);
    hit(4'd2);
    chk("restart_hit", 32'(enemy_state), 32'h7FFB);

    rst_n = 1'b0;
    #1;
    chk("async_enemy",   32'(enemy_state), 32'h0);
    chk("async_running", 32'(running),     32'h0);
    chk("async_stage",   32'(stage_state), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
